game_state_regs: RTL and testbench
==================================

# game_state_regs

Holds the persistent game state (score, eaten-fruit mask, lives used) and the countdown timer that the game-logic FSM reads back every cycle, and commits that FSM's load strobes. Also runs a serial shift-add BCD converter, so the HUD renderer gets decimal score and time digits without a combinational divider. Sits directly downstream and upstream of the game-logic FSM: it consumes its `*_to_reg`/`Load_*` outputs and drives its `*_from_reg` and `counter` inputs.

## Interface
- TIME_LIMIT, 120: starting countdown in seconds; legal range 1..999.
- TICKS_PER_SEC, 60: frame_clk rising edges per second.
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  VGA vsync-rate pulse, asynchronous to Clk.
- keycode  in  8  current USB keycode.
- restart, win, lose  in  1 each  game-logic status outputs.
- Load_S, Load_F, Load_L  in  1 each  register load strobes.
- score_to_reg  in  10  new score.
- fruits_to_reg  in  4  new fruit mask.
- lives_to_reg  in  8  new lives-used count; only bits [1:0] are stored.
- score_from_reg  out  10  current score.
- fruits_from_reg  out  4  bit i set = fruit i eaten.
- lives_from_reg  out  2  lives used, 0..3.
- counter  out  32  seconds remaining; bits [31:10] are always 0.
- score_bcd  out  16  four BCD digits of score, thousands in bits [15:12].
- time_bcd  out  12  three BCD digits of counter.
- bcd_valid  out  1  high once score_bcd/time_bcd hold a completed conversion.

## Operation
- **State registers**
  - Reset or restart: score=0, fruits=0, lives=0. Restart overrides any Load_* asserted in the same cycle.
  - Otherwise each Load_x loads its `_to_reg` value at the clock edge. Strobes are independent; simultaneous strobes all commit.
- **Frame tick**
  - frame_clk passes through a 2-flop synchroniser; a rising edge of the synchronised signal gives a 1-cycle `tick`.
- **Start flag**
  - `started` is cleared by Reset or restart.
  - It is set when keycode ∈ {0x04, 0x07, 0x16, 0x1A}.
- **Prescaler**
  - Counts ticks 0..TICKS_PER_SEC-1.
  - Held at 0 while !started, win, or lose.
  - On a tick at TICKS_PER_SEC-1 it wraps to 0 and pulses `sec`.
- **Countdown**
  - Reset or restart: counter=TIME_LIMIT.
  - On `sec` with counter≠0: decrement by 1.
  - Saturates at 0 and never wraps.
  - Frozen while win or lose.
- **BCD converter**
  - Registers: `dirty`, plus copies score_seen/counter_seen.
  - `dirty` is set the cycle after score or counter differs from its seen copy; the seen copies update at the same edge.
  - `dirty` resets to 1.
  - FSM states:
    - IDLE: if dirty, snapshot score and counter[9:0], clear dirty, go to S_CONV.
    - S_CONV: 10 double-dabble steps on the score snapshot (add 3 to each digit ≥5, then shift left 1), one step per cycle, then go to T_CONV.
    - T_CONV: 10 steps on the time snapshot, then go to DONE.
    - DONE: write score_bcd and time_bcd together, set bcd_valid, return to IDLE.
  - A change during conversion sets dirty again, and a new conversion starts from IDLE afterwards. Outputs never show a partial result.
- **Reset values**
  - score_from_reg, fruits_from_reg, lives_from_reg = 0.
  - counter = TIME_LIMIT.
  - score_bcd, time_bcd, bcd_valid = 0.
  - FSM = IDLE.
  - Reset mid-conversion aborts it.

## Timing
- Load_* → `_from_reg` visible 1 cycle after the strobe edge.
- restart → counter=TIME_LIMIT and registers=0 on the next edge.
- frame_clk rising edge → tick 3 Clk edges later.
- A counter decrement occurs on the edge after the TICKS_PER_SEC-th tick counted since started/wrap.
- Register change at edge k → dirty at k+1 → snapshot at k+2 → S_CONV k+3..k+12 → T_CONV k+13..k+22 → BCD outputs update at edge k+23. Worst case, including one in-flight conversion, is k+45.
- After Reset deasserts, the first conversion completes 22 cycles later, giving score_bcd=0x0000 and time_bcd=0x120 (defaults).

## Test plan
- **Reset defaults:** Reset 1 cycle → all registers 0, counter=120; 22 cycles later bcd_valid=1, time_bcd=0x120, score_bcd=0x0000.
- **Loads and restart priority:** Load_S with 50 → score 50, score_bcd=0x0050 at k+23. Load_F with 0x5 and Load_L with 8'h02 in the same cycle → fruits=0x5, lives=2. restart together with Load_S with 100 → score stays 0.
- **Countdown gating:** TICKS_PER_SEC=2, TIME_LIMIT=3, no key → counter stays 3. keycode 0x07, then 2 frame pulses → counter=2. 6 further pulses → counter=0 and stays 0.
- **Freeze:** counter=2, lose held high, 4 frame pulses → counter stays 2 and the prescaler stays 0.
- **Conversion overlap:** Load_S with 1023; 5 cycles later Load_S with 999 → first output 0x1023, then 0x0999 within 45 cycles of the first load; score_bcd never shows any other intermediate value.
- **Reset mid-conversion:** Reset asserted during T_CONV → bcd_valid=0 and BCD outputs 0; a fresh conversion then produces time_bcd=0x120.

Source files
------------

// File: rtl/game_state_regs.sv
// game_state_regs: persistent game state, countdown timer and serial BCD conversion for the HUD.
module game_state_regs #(
  parameter int TIME_LIMIT = 120,
  parameter int TICKS_PER_SEC = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        restart,
  input  logic        win,
  input  logic        lose,
  input  logic        Load_S,
  input  logic        Load_F,
  input  logic        Load_L,
  input  logic [9:0]  score_to_reg,
  input  logic [3:0]  fruits_to_reg,
  input  logic [7:0]  lives_to_reg,
  output logic [9:0]  score_from_reg,
  output logic [3:0]  fruits_from_reg,
  output logic [1:0]  lives_from_reg,
  output logic [31:0] counter,
  output logic [15:0] score_bcd,
  output logic [11:0] time_bcd,
  output logic        bcd_valid
);
  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [9:0] TL = 10'(TIME_LIMIT);
  typedef enum logic [1:0] {IDLE, S_CONV, T_CONV, DONE} state_t;
  state_t state, state_n;
  logic [2:0] fs;
  logic [PW-1:0] pre;
  logic [9:0] cnt, score_seen, cnt_seen, sbin, tbin;
  logic [15:0] sacc;
  logic [11:0] tacc, tdab;
  logic [3:0] step;
  logic started, tick, run, sec, key_go, dirty;
  logic unused;
  function automatic logic [15:0] dab(input logic [15:0] b);
    for (int i = 0; i < 4; i++) dab[i*4+:4] = b[i*4+:4] >= 4'd5 ? b[i*4+:4] + 4'd3 : b[i*4+:4];
  endfunction
  assign unused = ^lives_to_reg[7:2];
  assign tick = fs[1] & ~fs[2];
  assign run = started & ~win & ~lose;
  assign sec = tick & run & (pre == PMAX);
  assign key_go = keycode == 8'h04 || keycode == 8'h07 || keycode == 8'h16 || keycode == 8'h1A;
  assign counter = {22'd0, cnt};
  assign tdab = 12'(dab({4'd0, tacc}));
  always_ff @(posedge Clk)
    fs <= Reset ? 3'd0 : {fs[1:0], frame_clk};
  always_ff @(posedge Clk) begin
    if (Reset || restart) begin
      score_from_reg <= '0;
      fruits_from_reg <= '0;
      lives_from_reg <= '0;
      cnt <= TL;
      started <= 1'b0;
      pre <= '0;
    end else begin
      if (Load_S) score_from_reg <= score_to_reg;
      if (Load_F) fruits_from_reg <= fruits_to_reg;
      if (Load_L) lives_from_reg <= lives_to_reg[1:0];
      if (key_go) started <= 1'b1;
      pre <= !run ? '0 : tick ? (pre == PMAX ? '0 : pre + PW'(1)) : pre;
      if (sec && cnt != 10'd0) cnt <= cnt - 10'd1;
    end
  end
  // Any change since the last look requests a new conversion; a pending request outranks the IDLE clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dirty <= 1'b1;
      score_seen <= '0;
      cnt_seen <= TL;
    end else begin
      score_seen <= score_from_reg;
      cnt_seen <= cnt;
      dirty <= (score_from_reg != score_seen || cnt != cnt_seen) ? 1'b1 : state == IDLE ? 1'b0 : dirty;
    end
  end
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = dirty ? S_CONV : IDLE;
      S_CONV:  state_n = step == 4'd9 ? T_CONV : S_CONV;
      T_CONV:  state_n = step == 4'd9 ? DONE : T_CONV;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      step <= '0;
      sacc <= '0;
      sbin <= '0;
      tacc <= '0;
      tbin <= '0;
      score_bcd <= '0;
      time_bcd <= '0;
      bcd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dirty) begin
          sbin <= score_from_reg;
          tbin <= cnt;
          sacc <= '0;
          tacc <= '0;
          step <= '0;
        end
        S_CONV: begin
          {sacc, sbin} <= {dab(sacc), sbin} << 1;
          step <= step == 4'd9 ? 4'd0 : step + 4'd1;
        end
        T_CONV: begin
          {tacc, tbin} <= {tdab, tbin} << 1;
          step <= step == 4'd9 ? 4'd0 : step + 4'd1;
        end
        default: begin
          score_bcd <= sacc;
          time_bcd <= tacc;
          bcd_valid <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_game_state_regs.sv
// tb_game_state_regs: directed and randomized checks of game_state_regs against a behavioural model.
module tb_game_state_regs;
  localparam int TL = 120;
  localparam int TPS = 3;
  logic Clk = 0, Reset = 1, frame_clk = 0, restart = 0, win = 0, lose = 0;
  logic Load_S = 0, Load_F = 0, Load_L = 0;
  logic [7:0] keycode = 0, lives_to_reg = 0;
  logic [9:0] score_to_reg = 0;
  logic [3:0] fruits_to_reg = 0;
  logic [9:0] score_from_reg;
  logic [3:0] fruits_from_reg;
  logic [1:0] lives_from_reg;
  logic [31:0] counter;
  logic [15:0] score_bcd;
  logic [11:0] time_bcd;
  logic bcd_valid;
  int checks = 0, errors = 0;
  int sm, fm, lm, cm, acc;
  bit st;
  logic [7:0] keys [4] = '{8'h04, 8'h07, 8'h16, 8'h1A};

  game_state_regs #(.TIME_LIMIT(TL), .TICKS_PER_SEC(TPS)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .restart(restart), .win(win), .lose(lose),
    .Load_S(Load_S), .Load_F(Load_F), .Load_L(Load_L),
    .score_to_reg(score_to_reg), .fruits_to_reg(fruits_to_reg), .lives_to_reg(lives_to_reg),
    .score_from_reg(score_from_reg), .fruits_from_reg(fruits_from_reg), .lives_from_reg(lives_from_reg),
    .counter(counter), .score_bcd(score_bcd), .time_bcd(time_bcd), .bcd_valid(bcd_valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] bcd(input int v);
    return 16'((v / 1000 % 10) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10);
  endfunction

  task automatic model_clear;
    sm = 0; fm = 0; lm = 0; cm = TL; st = 0; acc = 0;
  endtask

  task automatic gate;
    if (!(st && !win && !lose)) acc = 0;
  endtask

  task automatic chk_regs(input string t);
    chk({t, "_score"}, 32'(score_from_reg), sm);
    chk({t, "_fruits"}, 32'(fruits_from_reg), fm);
    chk({t, "_lives"}, 32'(lives_from_reg), lm);
    chk({t, "_counter"}, counter, cm);
  endtask

  task automatic load(input bit s, input bit f, input bit l, input int sv, input int fv, input int lv, input bit rs);
    Load_S = s; Load_F = f; Load_L = l; restart = rs;
    score_to_reg = 10'(sv); fruits_to_reg = 4'(fv); lives_to_reg = 8'(lv);
    cyc;
    Load_S = 0; Load_F = 0; Load_L = 0; restart = 0;
    if (rs) model_clear;
    else begin
      if (s) sm = sv;
      if (f) fm = fv;
      if (l) lm = lv % 4;
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    cyc;
    keycode = 0;
    if (k inside {8'h04, 8'h07, 8'h16, 8'h1A}) st = 1;
    gate;
  endtask

  task automatic pulse;
    frame_clk = 1;
    repeat (4) cyc;
    frame_clk = 0;
    repeat (4) cyc;
    if (st && !win && !lose) begin
      acc++;
      if (acc == TPS) begin
        acc = 0;
        if (cm > 0) cm--;
      end
    end
  endtask

  task automatic settle(input string t);
    repeat (50) cyc;
    chk({t, "_valid"}, 32'(bcd_valid), 1);
    chk({t, "_sbcd"}, 32'(score_bcd), 32'(bcd(sm)));
    chk({t, "_tbcd"}, 32'(time_bcd), 32'(bcd(cm)));
  endtask

  initial begin
    int bad;
    model_clear;
    cyc; cyc;
    Reset = 0;
    chk_regs("rst");
    chk("rst_valid", 32'(bcd_valid), 0);
    chk("rst_sbcd", 32'(score_bcd), 0);
    chk("rst_tbcd", 32'(time_bcd), 0);
    repeat (21) cyc;
    chk("rst_valid_early", 32'(bcd_valid), 0);
    cyc;
    chk("rst_valid_22", 32'(bcd_valid), 1);
    chk("rst_tbcd_22", 32'(time_bcd), 32'h120);
    chk("rst_sbcd_22", 32'(score_bcd), 0);

    load(1, 0, 0, 50, 0, 0, 0);
    chk_regs("ld_s");
    repeat (22) cyc;
    chk("ld_s_bcd_early", 32'(score_bcd), 0);
    cyc;
    chk("ld_s_bcd_k23", 32'(score_bcd), 32'h0050);
    load(0, 1, 1, 0, 5, 2, 0);
    chk_regs("ld_fl");
    chk("ld_fl_fruits", 32'(fruits_from_reg), 5);
    chk("ld_fl_lives", 32'(lives_from_reg), 2);
    load(1, 0, 0, 100, 0, 0, 1);
    chk_regs("restart_pri");
    chk("restart_pri_score", 32'(score_from_reg), 0);
    settle("after_restart");

    repeat (3) pulse;
    chk("nokey_cnt", counter, TL);
    press(8'h05);
    repeat (3) pulse;
    chk("badkey_cnt", counter, TL);
    press(8'h07);
    pulse; pulse;
    chk("two_ticks_cnt", counter, TL);
    pulse;
    chk("one_sec_cnt", counter, TL - 1);
    chk_regs("countdown");

    pulse;
    lose = 1; gate;
    repeat (4) pulse;
    chk("freeze_cnt", counter, TL - 1);
    lose = 0; gate;
    pulse; pulse;
    chk("presc_zero_cnt", counter, TL - 1);
    pulse;
    chk("after_freeze_cnt", counter, TL - 2);

    repeat ((TL - 2) * TPS + 6) pulse;
    chk("sat_cnt", counter, 0);
    chk_regs("sat");
    settle("sat_bcd");

    load(0, 0, 0, 0, 0, 0, 1);
    settle("pre_ovl");
    load(1, 0, 0, 1023, 0, 0, 0);
    bad = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 5) begin
        Load_S = 1; score_to_reg = 10'd999;
      end
      cyc;
      Load_S = 0;
      if (i == 5) sm = 999;
      if (!(score_bcd inside {16'h0000, 16'h1023, 16'h0999})) bad++;
      if (i == 22) chk("ovl_k22", 32'(score_bcd), 0);
      if (i == 23) chk("ovl_k23", 32'(score_bcd), 32'h1023);
      if (i == 44) chk("ovl_k44", 32'(score_bcd), 32'h1023);
      if (i == 45) chk("ovl_k45", 32'(score_bcd), 32'h0999);
    end
    chk("ovl_illegal", bad, 0);
    chk_regs("ovl");

    load(1, 0, 0, 321, 0, 0, 0);
    repeat (15) cyc;
    Reset = 1;
    cyc;
    Reset = 0;
    model_clear;
    chk("midrst_valid", 32'(bcd_valid), 0);
    chk("midrst_sbcd", 32'(score_bcd), 0);
    chk("midrst_tbcd", 32'(time_bcd), 0);
    chk_regs("midrst");
    repeat (22) cyc;
    chk("midrst_valid_22", 32'(bcd_valid), 1);
    chk("midrst_tbcd_22", 32'(time_bcd), 32'h120);
    chk("midrst_sbcd_22", 32'(score_bcd), 0);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0, 1: load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 1023), $urandom_range(0, 15), $urandom_range(0, 255),
                   $urandom_range(0, 7) == 0);
        2: press($urandom_range(0, 1) ? keys[$urandom_range(0, 3)] : 8'($urandom_range(0, 255)));
        3: begin
          win = $urandom_range(0, 4) == 0;
          lose = $urandom_range(0, 4) == 0;
          gate;
        end
        default: pulse;
      endcase
      chk_regs("rnd");
      if (n % 20 == 19) settle("rnd_bcd");
    end
    win = 0; lose = 0;
    settle("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
